// File: rtl/mc_controller_gen.sv
// Multicycle MIPS control FSM with a MEM_WIDTH-wide fetch bus and memready-stalled memory beats.
// Optional BNE decode is enabled by defining MC_CTRL_BNE_EN.
module mc_controller_gen #(
  parameter int unsigned MEM_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [5:0]                 op,
  input  logic                       zero,
  input  logic                       memready,
  output logic                       memread,
  output logic                       memwrite,
  output logic                       iord,
  output logic                       alusrca,
  output logic [1:0]                 alusrcb,
  output logic [1:0]                 aluop,
  output logic [1:0]                 pcsource,
  output logic                       pcen,
  output logic [32/MEM_WIDTH-1:0]    irwrite,
  output logic                       regwrite,
  output logic                       regdst,
  output logic                       memtoreg,
  output logic                       illegal
);

  localparam int unsigned BEATS  = 32 / MEM_WIDTH;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MC_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTYPEEX,
    S_RTYPEWB,
    S_BRANCHEX,
    S_ADDIEX,
    S_LOGIEX,
    S_IMMWB,
    S_JEX
  } state_t;

  state_t              state_q, state_d;
  state_t              dec_state;
  logic                op_legal;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [BEATS-1:0]    beat_onehot;

  // State and beat counter; reset abandons any in-flight instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Opcode decode, only consumed while in DECODE.
  always_comb begin
    dec_state = S_FETCH;
    op_legal  = 1'b1;
    case (op)
      OP_LW, OP_SW:     dec_state = S_MEMADR;
      OP_RTYPE:         dec_state = S_RTYPEEX;
      OP_BEQ:           dec_state = S_BRANCHEX;
`ifdef MC_CTRL_BNE_EN
      OP_BNE:           dec_state = S_BRANCHEX;
`endif
      OP_ADDI:          dec_state = S_ADDIEX;
      OP_ANDI, OP_ORI:  dec_state = S_LOGIEX;
      OP_J:             dec_state = S_JEX;
      default: begin
        dec_state = S_FETCH;
        op_legal  = 1'b0;
      end
    endcase
  end

  // Next state: memory states hold until memready, fetch advances one beat per ready.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      S_FETCH: begin
        if (memready) begin
          if (beat_q == LAST_BEAT) begin
            state_d = S_DECODE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      S_DECODE:   state_d = dec_state;
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    if (memready) state_d = S_MEMWB;
      S_MEMWR:    if (memready) state_d = S_FETCH;
      S_RTYPEEX:  state_d = S_RTYPEWB;
      S_ADDIEX:   state_d = S_IMMWB;
      S_LOGIEX:   state_d = S_IMMWB;
      S_MEMWB, S_RTYPEWB, S_BRANCHEX, S_IMMWB, S_JEX:
                  state_d = S_FETCH;
      default: begin
        state_d = S_FETCH;
        beat_d  = '0;
      end
    endcase
  end

  always_comb begin
    beat_onehot = BEATS'(1) << beat_q;
  end

  // Moore decode of the state; fetch strobes gated by memready, branch pcen by zero.
  always_comb begin
    memread  = 1'b0;
    memwrite = 1'b0;
    iord     = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    aluop    = 2'b00;
    pcsource = 2'b00;
    pcen     = 1'b0;
    irwrite  = '0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = beat_onehot & {BEATS{memready}};
        pcen    = memready;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        illegal = ~op_legal;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_RTYPEWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BRANCHEX: begin
        alusrca  = 1'b1;
        aluop    = 2'b01;
        pcsource = 2'b01;
`ifdef MC_CTRL_BNE_EN
        pcen     = (op == OP_BNE) ? ~zero : zero;
`else
        pcen     = zero;
`endif
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_LOGIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = 2'b11;
      end
      S_IMMWB: begin
        regwrite = 1'b1;
      end
      S_JEX: begin
        pcsource = 2'b10;
        pcen     = 1'b1;
      end
      default: begin
        memread = 1'b0;
      end
    endcase

    // Reset silences every control line in the same cycle.
    if (rst) begin
      memread  = 1'b0;
      memwrite = 1'b0;
      iord     = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      aluop    = 2'b00;
      pcsource = 2'b00;
      pcen     = 1'b0;
      irwrite  = '0;
      regwrite = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_controller_gen.sv
// Bench for mc_controller_gen: three bus widths share stimulus, a vector table feeds a scoreboard.
module tb_mc_controller_gen;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       pcen;
    logic [3:0] irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       illegal;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       zero;
    logic       mr;
    logic [1:0] inst;
    outs_t      exp;
  } vec_t;

  typedef struct {
    logic [1:0] inst;
    int         id;
    outs_t      exp;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = '0;
  logic       zero = 1'b0;
  logic       memready = 1'b0;

  logic [2:0] memread_v, memwrite_v, iord_v, alusrca_v, pcen_v;
  logic [2:0] regwrite_v, regdst_v, memtoreg_v, illegal_v;
  logic [1:0] alusrcb_v [3];
  logic [1:0] aluop_v [3];
  logic [1:0] pcsource_v [3];
  logic [3:0] irw8;
  logic [1:0] irw16;
  logic [0:0] irw32;

  vec_t vecs[$];
  sb_t  sb[$];
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  mc_controller_gen #(.MEM_WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .memready(memready),
    .memread(memread_v[0]), .memwrite(memwrite_v[0]), .iord(iord_v[0]),
    .alusrca(alusrca_v[0]), .alusrcb(alusrcb_v[0]), .aluop(aluop_v[0]),
    .pcsource(pcsource_v[0]), .pcen(pcen_v[0]), .irwrite(irw8),
    .regwrite(regwrite_v[0]), .regdst(regdst_v[0]), .memtoreg(memtoreg_v[0]),
    .illegal(illegal_v[0])
  );

  mc_controller_gen #(.MEM_WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .memready(memready),
    .memread(memread_v[1]), .memwrite(memwrite_v[1]), .iord(iord_v[1]),
    .alusrca(alusrca_v[1]), .alusrcb(alusrcb_v[1]), .aluop(aluop_v[1]),
    .pcsource(pcsource_v[1]), .pcen(pcen_v[1]), .irwrite(irw16),
    .regwrite(regwrite_v[1]), .regdst(regdst_v[1]), .memtoreg(memtoreg_v[1]),
    .illegal(illegal_v[1])
  );

  mc_controller_gen #(.MEM_WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .memready(memready),
    .memread(memread_v[2]), .memwrite(memwrite_v[2]), .iord(iord_v[2]),
    .alusrca(alusrca_v[2]), .alusrcb(alusrcb_v[2]), .aluop(aluop_v[2]),
    .pcsource(pcsource_v[2]), .pcen(pcen_v[2]), .irwrite(irw32),
    .regwrite(regwrite_v[2]), .regdst(regdst_v[2]), .memtoreg(memtoreg_v[2]),
    .illegal(illegal_v[2])
  );

  // Expected output words, one per state, written straight from the control table.
  function automatic outs_t o_none();
    outs_t o;
    o = '0;
    return o;
  endfunction

  function automatic outs_t o_fetch(input logic [3:0] irw, input logic pe);
    outs_t o;
    o = '0;
    o.memread = 1'b1; o.alusrcb = 2'b01; o.irwrite = irw; o.pcen = pe;
    return o;
  endfunction

  function automatic outs_t o_dec(input logic ill);
    outs_t o;
    o = '0;
    o.alusrcb = 2'b11; o.illegal = ill;
    return o;
  endfunction

  function automatic outs_t o_adr();
    outs_t o;
    o = '0;
    o.alusrca = 1'b1; o.alusrcb = 2'b10;
    return o;
  endfunction

  function automatic outs_t o_mrd();
    outs_t o;
    o = '0;
    o.memread = 1'b1; o.iord = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_mwb();
    outs_t o;
    o = '0;
    o.regwrite = 1'b1; o.memtoreg = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_mwr();
    outs_t o;
    o = '0;
    o.memwrite = 1'b1; o.iord = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_rex();
    outs_t o;
    o = '0;
    o.alusrca = 1'b1; o.aluop = 2'b10;
    return o;
  endfunction

  function automatic outs_t o_rwb();
    outs_t o;
    o = '0;
    o.regwrite = 1'b1; o.regdst = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_br(input logic pe);
    outs_t o;
    o = '0;
    o.alusrca = 1'b1; o.aluop = 2'b01; o.pcsource = 2'b01; o.pcen = pe;
    return o;
  endfunction

  function automatic outs_t o_logi();
    outs_t o;
    o = '0;
    o.alusrca = 1'b1; o.alusrcb = 2'b10; o.aluop = 2'b11;
    return o;
  endfunction

  function automatic outs_t o_immwb();
    outs_t o;
    o = '0;
    o.regwrite = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_jex();
    outs_t o;
    o = '0;
    o.pcsource = 2'b10; o.pcen = 1'b1;
    return o;
  endfunction

  function automatic outs_t actual(input logic [1:0] i);
    outs_t a;
    a = '0;
    a.memread  = memread_v[i];
    a.memwrite = memwrite_v[i];
    a.iord     = iord_v[i];
    a.alusrca  = alusrca_v[i];
    a.alusrcb  = alusrcb_v[i];
    a.aluop    = aluop_v[i];
    a.pcsource = pcsource_v[i];
    a.pcen     = pcen_v[i];
    a.regwrite = regwrite_v[i];
    a.regdst   = regdst_v[i];
    a.memtoreg = memtoreg_v[i];
    a.illegal  = illegal_v[i];
    case (i)
      2'd0:    a.irwrite = irw8;
      2'd1:    a.irwrite = {2'b00, irw16};
      default: a.irwrite = {3'b000, irw32};
    endcase
    return a;
  endfunction

  task automatic add(input logic r, input logic [5:0] o, input logic z, input logic m,
                     input logic [1:0] inst, input outs_t e);
    vec_t v;
    v.rst = r; v.op = o; v.zero = z; v.mr = m; v.inst = inst; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic rst_v(input logic [1:0] inst);
    add(1'b1, OP_R, 1'b0, 1'b1, inst, o_none());
  endtask

  // Four byte-wide fetch beats with memready high.
  task automatic f8(input logic [5:0] o);
    add(1'b0, o, 1'b0, 1'b1, 2'd0, o_fetch(4'b0001, 1'b1));
    add(1'b0, o, 1'b0, 1'b1, 2'd0, o_fetch(4'b0010, 1'b1));
    add(1'b0, o, 1'b0, 1'b1, 2'd0, o_fetch(4'b0100, 1'b1));
    add(1'b0, o, 1'b0, 1'b1, 2'd0, o_fetch(4'b1000, 1'b1));
  endtask

  task automatic drive(input logic r, input logic [5:0] o, input logic z, input logic m);
    @(posedge clk);
    #1;
    rst = r; op = o; zero = z; memready = m;
  endtask

  task automatic step(input logic r, input logic [5:0] o, input logic z, input logic m,
                      input logic [1:0] inst, input outs_t e, input int id);
    sb_t s;
    drive(r, o, z, m);
    s.inst = inst; s.id = id; s.exp = e;
    sb.push_back(s);
  endtask

  // Scoreboard: each entry is compared at the falling edge of the cycle it was driven in.
  always @(negedge clk) begin
    sb_t   e;
    outs_t a;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = actual(e.inst);
      n_checks++;
      if (a === e.exp) n_pass++;
      else $display("FAIL vec%0d inst%0d: outputs got %05h want %05h", e.id, e.inst, a, e.exp);
    end
  end

  initial begin
    bit      found;
    int unsigned stall;

    // R-type, 8-bit bus, memready high: 7 cycles.
    rst_v(2'd0); f8(OP_R);
    add(1'b0, OP_R, 1'b0, 1'b1, 2'd0, o_dec(1'b0));
    add(1'b0, OP_R, 1'b0, 1'b1, 2'd0, o_rex());
    add(1'b0, OP_R, 1'b0, 1'b1, 2'd0, o_rwb());
    add(1'b0, OP_R, 1'b0, 1'b1, 2'd0, o_fetch(4'b0001, 1'b1));
    // LW, 32-bit bus, two stall cycles in MEMRD.
    rst_v(2'd2);
    add(1'b0, OP_LW, 1'b0, 1'b1, 2'd2, o_fetch(4'b0001, 1'b1));
    add(1'b0, OP_LW, 1'b0, 1'b1, 2'd2, o_dec(1'b0));
    add(1'b0, OP_LW, 1'b0, 1'b1, 2'd2, o_adr());
    add(1'b0, OP_LW, 1'b0, 1'b0, 2'd2, o_mrd());
    add(1'b0, OP_LW, 1'b0, 1'b0, 2'd2, o_mrd());
    add(1'b0, OP_LW, 1'b0, 1'b1, 2'd2, o_mrd());
    add(1'b0, OP_LW, 1'b0, 1'b1, 2'd2, o_mwb());
    add(1'b0, OP_LW, 1'b0, 1'b1, 2'd2, o_fetch(4'b0001, 1'b1));
    // BEQ taken and not taken.
    rst_v(2'd0); f8(OP_BEQ);
    add(1'b0, OP_BEQ, 1'b1, 1'b1, 2'd0, o_dec(1'b0));
    add(1'b0, OP_BEQ, 1'b1, 1'b1, 2'd0, o_br(1'b1));
    add(1'b0, OP_BEQ, 1'b1, 1'b1, 2'd0, o_fetch(4'b0001, 1'b1));
    rst_v(2'd2);
    add(1'b0, OP_BEQ, 1'b0, 1'b1, 2'd2, o_fetch(4'b0001, 1'b1));
    add(1'b0, OP_BEQ, 1'b0, 1'b1, 2'd2, o_dec(1'b0));
    add(1'b0, OP_BEQ, 1'b0, 1'b1, 2'd2, o_br(1'b0));
    add(1'b0, OP_BEQ, 1'b0, 1'b1, 2'd2, o_fetch(4'b0001, 1'b1));
    // Op 000101: inverted branch when BNE is built in, otherwise illegal.
    rst_v(2'd0); f8(OP_BNE);
`ifdef MC_CTRL_BNE_EN
    add(1'b0, OP_BNE, 1'b1, 1'b1, 2'd0, o_dec(1'b0));
    add(1'b0, OP_BNE, 1'b1, 1'b1, 2'd0, o_br(1'b0));
    add(1'b0, OP_BNE, 1'b1, 1'b1, 2'd0, o_fetch(4'b0001, 1'b1));
    rst_v(2'd2);
    add(1'b0, OP_BNE, 1'b0, 1'b1, 2'd2, o_fetch(4'b0001, 1'b1));
    add(1'b0, OP_BNE, 1'b0, 1'b1, 2'd2, o_dec(1'b0));
    add(1'b0, OP_BNE, 1'b0, 1'b1, 2'd2, o_br(1'b1));
`else
    add(1'b0, OP_BNE, 1'b1, 1'b1, 2'd0, o_dec(1'b1));
    add(1'b0, OP_BNE, 1'b1, 1'b1, 2'd0, o_fetch(4'b0001, 1'b1));
`endif
    // Illegal opcode pulses once and returns to fetch.
    rst_v(2'd0); f8(OP_BAD);
    add(1'b0, OP_BAD, 1'b0, 1'b1, 2'd0, o_dec(1'b1));
    add(1'b0, OP_BAD, 1'b0, 1'b1, 2'd0, o_fetch(4'b0001, 1'b1));
    add(1'b0, OP_BAD, 1'b0, 1'b1, 2'd0, o_fetch(4'b0010, 1'b1));
    // 16-bit bus, stall on beat 1, then ADDI.
    rst_v(2'd1);
    add(1'b0, OP_ADDI, 1'b0, 1'b1, 2'd1, o_fetch(4'b0001, 1'b1));
    add(1'b0, OP_ADDI, 1'b0, 1'b0, 2'd1, o_fetch(4'b0000, 1'b0));
    add(1'b0, OP_ADDI, 1'b0, 1'b0, 2'd1, o_fetch(4'b0000, 1'b0));
    add(1'b0, OP_ADDI, 1'b0, 1'b1, 2'd1, o_fetch(4'b0010, 1'b1));
    add(1'b0, OP_ADDI, 1'b0, 1'b1, 2'd1, o_dec(1'b0));
    add(1'b0, OP_ADDI, 1'b0, 1'b1, 2'd1, o_adr());
    add(1'b0, OP_ADDI, 1'b0, 1'b1, 2'd1, o_immwb());
    add(1'b0, OP_ADDI, 1'b0, 1'b1, 2'd1, o_fetch(4'b0001, 1'b1));
    // Reset during fetch beat 2 restarts at beat 0.
    rst_v(2'd0);
    add(1'b0, OP_R, 1'b0, 1'b1, 2'd0, o_fetch(4'b0001, 1'b1));
    add(1'b0, OP_R, 1'b0, 1'b1, 2'd0, o_fetch(4'b0010, 1'b1));
    add(1'b1, OP_R, 1'b0, 1'b1, 2'd0, o_none());
    add(1'b0, OP_R, 1'b0, 1'b1, 2'd0, o_fetch(4'b0001, 1'b1));
    add(1'b0, OP_R, 1'b0, 1'b1, 2'd0, o_fetch(4'b0010, 1'b1));
    // ORI on 8-bit, ANDI on 32-bit.
    rst_v(2'd0); f8(OP_ORI);
    add(1'b0, OP_ORI, 1'b0, 1'b1, 2'd0, o_dec(1'b0));
    add(1'b0, OP_ORI, 1'b0, 1'b1, 2'd0, o_logi());
    add(1'b0, OP_ORI, 1'b0, 1'b1, 2'd0, o_immwb());
    add(1'b0, OP_ORI, 1'b0, 1'b1, 2'd0, o_fetch(4'b0001, 1'b1));
    rst_v(2'd2);
    add(1'b0, OP_ANDI, 1'b0, 1'b1, 2'd2, o_fetch(4'b0001, 1'b1));
    add(1'b0, OP_ANDI, 1'b0, 1'b1, 2'd2, o_dec(1'b0));
    add(1'b0, OP_ANDI, 1'b0, 1'b1, 2'd2, o_logi());
    add(1'b0, OP_ANDI, 1'b0, 1'b1, 2'd2, o_immwb());
    // Jump on 32-bit bus after a fetch stall.
    rst_v(2'd2);
    add(1'b0, OP_J, 1'b0, 1'b0, 2'd2, o_fetch(4'b0000, 1'b0));
    add(1'b0, OP_J, 1'b0, 1'b1, 2'd2, o_fetch(4'b0001, 1'b1));
    add(1'b0, OP_J, 1'b0, 1'b1, 2'd2, o_dec(1'b0));
    add(1'b0, OP_J, 1'b0, 1'b1, 2'd2, o_jex());
    add(1'b0, OP_J, 1'b0, 1'b1, 2'd2, o_fetch(4'b0001, 1'b1));
    // SW with a stall, then reset in the middle of a MEMRD stall.
    rst_v(2'd2);
    add(1'b0, OP_SW, 1'b0, 1'b1, 2'd2, o_fetch(4'b0001, 1'b1));
    add(1'b0, OP_SW, 1'b0, 1'b1, 2'd2, o_dec(1'b0));
    add(1'b0, OP_SW, 1'b0, 1'b1, 2'd2, o_adr());
    add(1'b0, OP_SW, 1'b0, 1'b0, 2'd2, o_mwr());
    add(1'b0, OP_SW, 1'b0, 1'b1, 2'd2, o_mwr());
    add(1'b0, OP_LW, 1'b0, 1'b1, 2'd2, o_fetch(4'b0001, 1'b1));
    add(1'b0, OP_LW, 1'b0, 1'b1, 2'd2, o_dec(1'b0));
    add(1'b0, OP_LW, 1'b0, 1'b1, 2'd2, o_adr());
    add(1'b0, OP_LW, 1'b0, 1'b0, 2'd2, o_mrd());
    add(1'b1, OP_LW, 1'b0, 1'b0, 2'd2, o_none());
    add(1'b0, OP_LW, 1'b0, 1'b1, 2'd2, o_fetch(4'b0001, 1'b1));

    foreach (vecs[i])
      step(vecs[i].rst, vecs[i].op, vecs[i].zero, vecs[i].mr, vecs[i].inst, vecs[i].exp, i);

    // SW on the 8-bit bus with a random-length MEMWR stall.
    step(1'b1, OP_SW, 1'b0, 1'b1, 2'd0, o_none(), 1000);
    found = 1'b0;
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, OP_SW, 1'b0, 1'b1);
      @(negedge clk);
      if (alusrca_v[0] && alusrcb_v[0] == 2'b10) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (found) n_pass++;
    else $display("FAIL sw_memadr_wait: MEMADR seen %0d, required 1", found);
    if (found) begin
      stall = $urandom_range(1, 4);
      for (int k = 0; k < int'(stall); k++)
        step(1'b0, OP_SW, 1'b0, 1'b0, 2'd0, o_mwr(), 1001 + k);
      step(1'b0, OP_SW, 1'b0, 1'b1, 2'd0, o_mwr(), 1010);
      step(1'b0, OP_SW, 1'b0, 1'b1, 2'd0, o_fetch(4'b0001, 1'b1), 1011);
      step(1'b0, OP_SW, 1'b0, 1'b1, 2'd0, o_fetch(4'b0010, 1'b1), 1012);
    end

    for (int k = 0; k < 8 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_checks++;
      $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_controller_gen.md
# mc_controller_gen

Parametrised multicycle control FSM for the MIPS datapath. It sequences instruction fetch over a configurable-width memory bus with one write-enable per IR slice, then decode, execute, memory and writeback. Every memory access stalls on a `memready` handshake, and it adds LW/SW, ANDI/ORI, an illegal-opcode flag and optional BNE. It sits between the instruction register opcode field and the datapath mux/enable controls.

## Interface
- `MEM_WIDTH`, default 8: memory data bus width in bits; legal values 8, 16, 32.
- `BEATS`, derived as 32/`MEM_WIDTH`: fetch beats per instruction; not overridable.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `op` in 6: opcode, IR[31:26].
- `zero` in 1: ALU zero flag.
- `memready` in 1: memory has completed the current read/write beat.
- `memread`, `memwrite` out 1: memory strobes.
- `iord` out 1: 1 selects the ALUOut address, 0 selects PC.
- `alusrca` out 1: 1 selects register A, 0 selects PC.
- `alusrcb` out 2: 00 B, 01 constant `MEM_WIDTH`/8, 10 sign-extended immediate, 11 immediate<<2.
- `aluop` out 2: 00 add, 01 sub, 10 funct, 11 logic-immediate (funct from op[1:0]).
- `pcsource` out 2: 00 ALU, 01 ALUOut, 10 jump target.
- `pcen` out 1: PC write enable.
- `irwrite` out `BEATS`: one-hot IR slice enable; bit k loads IR[`MEM_WIDTH`*(k+1)-1 : `MEM_WIDTH`*k].
- `regwrite`, `regdst`, `memtoreg` out 1: register file controls.
- `illegal` out 1: one-cycle pulse in DECODE for an unsupported op.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BRANCHEX, ADDIEX, LOGIEX, IMMWB, JEX.
- Beat counter: log2(`BEATS`) bits; 1 bit minimum, unused when `BEATS`=1.
- FETCH:
  - Outputs: `memread`=1, `alusrcb`=01, `irwrite`=onehot(beat) & {BEATS{memready}}, `pcen`=`memready`.
  - On `memready`: beat++. On the last beat with `memready`: go to DECODE, beat←0.
  - Without `memready`: hold state and beat, no writes.
- DECODE: `alusrcb`=11 (branch target precompute).
  - LW 100011 / SW 101011 → MEMADR.
  - R-type 000000 → RTYPEEX.
  - BEQ 000100 → BRANCHEX.
  - ADDI 001000 → ADDIEX.
  - ANDI 001100 / ORI 001101 → LOGIEX.
  - J 000010 → JEX.
  - Any other op: `illegal`=1 → FETCH.
- MEMADR: `alusrca`=1, `alusrcb`=10. LW → MEMRD; SW → MEMWR.
- MEMRD: `memread`=1, `iord`=1. Hold until `memready`, then → MEMWB.
- MEMWB: `regwrite`=1, `memtoreg`=1 → FETCH.
- MEMWR: `memwrite`=1, `iord`=1. Hold until `memready`, then → FETCH.
- RTYPEEX: `alusrca`=1, `aluop`=10 → RTYPEWB.
- RTYPEWB: `regwrite`=1, `regdst`=1 → FETCH.
- BRANCHEX: `alusrca`=1, `aluop`=01, `pcsource`=01. `pcen`=`zero` for BEQ, `~zero` for BNE → FETCH.
- ADDIEX: `alusrca`=1, `alusrcb`=10 → IMMWB.
- LOGIEX: `alusrca`=1, `alusrcb`=10, `aluop`=11 → IMMWB.
- IMMWB: `regwrite`=1, `regdst`=0 → FETCH.
- JEX: `pcsource`=10, `pcen`=1 → FETCH.
- All outputs not listed for a state are 0.

## Timing
- Outputs are Moore from state, except that `irwrite`/`pcen` in FETCH are gated by `memready` and `pcen` in BRANCHEX depends on `zero`.
- While `rst` is high, all outputs are forced to 0.
- The first rising edge with `rst`=1 sets state=FETCH, beat=0. Reset at any point, including mid-fetch or mid-stall, abandons the instruction.
- Minimum cycle counts with `memready` tied high:
  - fetch: `BEATS` cycles
  - R-type: `BEATS`+3
  - LW: `BEATS`+4
  - SW: `BEATS`+3
  - BEQ/BNE/J: `BEATS`+2
  - ADDI/ANDI/ORI: `BEATS`+3
- Each cycle of `memready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle, with no side effects.
- `op` is sampled only in DECODE, MEMADR and BRANCHEX. `op` is stable there because IR is not written outside FETCH.

## Configuration
- `MC_CTRL_BNE_EN` defined: op 000101 decodes to BRANCHEX with an inverted condition (`pcen`=`~zero`).
- Not defined: 000101 is illegal (`illegal` pulse, → FETCH). No BNE logic is synthesised.

## Test plan
- `MEM_WIDTH`=8, `memready`=1, R-type op:
  - `irwrite` sequence 0001, 0010, 0100, 1000 with `pcen`=1 on each.
  - DECODE, RTYPEEX, then RTYPEWB with `regwrite`=1, `regdst`=1, then FETCH; 7 cycles total.
- `MEM_WIDTH`=32, LW with `memready` low for 2 cycles in MEMRD:
  - `irwrite`=1 for 1 cycle.
  - MEMRD lasts 3 cycles; MEMWB shows `memtoreg`=1, `regwrite`=1; 7 cycles total.
- BEQ:
  - `zero`=1 gives `pcen`=1, `pcsource`=01 in BRANCHEX.
  - `zero`=0 gives `pcen`=0.
  - With `MC_CTRL_BNE_EN`, op 000101 gives the inverse of both.
- Op 111111:
  - `illegal`=1 for exactly 1 cycle in DECODE, next state FETCH, no `regwrite`/`memwrite`.
  - Without `MC_CTRL_BNE_EN`, op 000101 behaves the same.
- `MEM_WIDTH`=16, `memready`=0 during fetch beat 1:
  - `irwrite`=00 and `pcen`=0 for the stall cycles.
  - Then `irwrite`=10 when `memready` rises.
- `rst` asserted during beat 2 of a fetch (`MEM_WIDTH`=8):
  - Outputs are 0 that cycle.
  - The next cycle restarts at `irwrite`=0001.
